// File: rtl/activation_requant_packer.sv
// Requantizes 16-bit signed ReLU activations to 8-bit and packs four
// consecutive results into one lane vector, with valid/ready on both sides.
module activation_requant_packer #(
  parameter int SHIFT = 4,
  parameter int ROUND = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic        [7:0]  out_lane0,
  output logic        [7:0]  out_lane1,
  output logic        [7:0]  out_lane2,
  output logic        [7:0]  out_lane3,
  output logic               out_sat,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic {COLLECT, HOLD} state_t;

  localparam logic signed [17:0] RND = (ROUND != 0) ? 18'(1 << (SHIFT - 1)) : 18'd0;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  lane_q [4];
  logic [7:0]  lane_d [4];
  logic        sat_q, sat_d;

  logic signed [17:0] sum;
  logic signed [17:0] shifted;
  logic        [7:0]  q8;
  logic               samp_sat;
  logic               accept;

  always_comb begin
    sum      = {{2{in_data[15]}}, in_data} + RND;
    shifted  = sum >>> SHIFT;
    samp_sat = 1'b0;
    q8       = shifted[7:0];
    if (shifted < 18'sd0) begin
      q8 = 8'd0;
    end else if (shifted > 18'sd127) begin
      q8       = 8'd127;
      samp_sat = 1'b1;
    end
  end

  // While a vector is held, a new sample may only enter in the cycle it is taken.
  assign in_ready = !rst && ((state_q == HOLD) ? out_ready : 1'b1);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    for (int i = 0; i < 4; i++) lane_d[i] = lane_q[i];

    case (state_q)
      COLLECT: begin
        if (accept) begin
          lane_d[idx_q] = q8;
          sat_d         = sat_q | samp_sat;
          idx_d         = idx_q + 2'd1;
          if (idx_q == 2'd3 || flush) begin
            for (int i = 0; i < 4; i++) begin
              if (i > int'(idx_q)) lane_d[i] = 8'd0;
            end
            state_d = HOLD;
            idx_d   = 2'd0;
          end
        end else if (flush && idx_q != 2'd0) begin
          for (int i = 0; i < 4; i++) begin
            if (i >= int'(idx_q)) lane_d[i] = 8'd0;
          end
          state_d = HOLD;
          idx_d   = 2'd0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
          for (int i = 0; i < 4; i++) lane_d[i] = 8'd0;
          sat_d = 1'b0;
          idx_d = 2'd0;
          if (accept) begin
            lane_d[0] = q8;
            sat_d     = samp_sat;
            idx_d     = 2'd1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= 2'd0;
      sat_q   <= 1'b0;
      for (int i = 0; i < 4; i++) lane_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      for (int i = 0; i < 4; i++) lane_q[i] <= lane_d[i];
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_sat   = sat_q;
  assign out_lane0 = lane_q[0];
  assign out_lane1 = lane_q[1];
  assign out_lane2 = lane_q[2];
  assign out_lane3 = lane_q[3];

endmodule
